lc3_pipeline_controller: RTL and testbench



---
 rtl/lc3_pipeline_controller_pkg.sv | 57 +++++
 rtl/lc3_pipeline_controller_if.sv | 42 ++++
 rtl/lc3_pipeline_controller_bypass_detect.sv | 48 ++++
 rtl/lc3_pipeline_controller.sv | 157 +++++++++++++++
 tb/tb_lc3_pipeline_controller.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/lc3_pipeline_controller_pkg.sv
// Shared definitions for the LC-3 pipeline controller.
//   - LC-3 opcode constants (instruction bits [15:12])
//   - mem_state_t: encoding driven on the mem_state output
//   - ctrl_state_t: controller FSM states, numbered to match mem_state_t
//   - op-class helpers taking a 4-bit opcode
package lc3_ctrl_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic [1:0] {
        MEM_READ  = 2'd0,
        MEM_IND   = 2'd1,
        MEM_WRITE = 2'd2,
        MEM_IDLE  = 2'd3
    } mem_state_t;

    typedef enum logic [1:0] {
        S_MREAD  = 2'd0,
        S_MIND   = 2'd1,
        S_MWRITE = 2'd2,
        S_RUN    = 2'd3
    } ctrl_state_t;

    function automatic logic is_alu(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) || (op == OP_LEA);
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic is_ctrl(input logic [3:0] op);
        return (op == OP_BR) || (op == OP_JMP);
    endfunction

    // Instructions whose SR1 field (bits [8:6]) is a real register read.
    function automatic logic reads_sr1(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT) ||
               (op == OP_LDR) || (op == OP_STR) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/lc3_pipeline_controller_if.sv
// Handshake/control bundle between the LC-3 datapath and its controller.
//   Datapath -> controller: complete_instr, complete_data, ir_dec, ir_exe, nzp
//   Controller -> datapath: enable_updatePC, enable_fetch, enable_decode,
//                           enable_execute, enable_writeback, br_taken,
//                           bypass_alu_1, bypass_alu_2, bypass_mem_1, mem_state
// master = datapath side, slave = controller side.
interface lc3_pipeline_controller_if
    import lc3_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16
);
    logic               complete_instr;
    logic               complete_data;
    logic [INSTR_W-1:0] ir_dec;
    logic [INSTR_W-1:0] ir_exe;
    logic [2:0]         nzp;

    logic               enable_updatePC;
    logic               enable_fetch;
    logic               enable_decode;
    logic               enable_execute;
    logic               enable_writeback;
    logic               br_taken;
    logic               bypass_alu_1;
    logic               bypass_alu_2;
    logic               bypass_mem_1;
    mem_state_t         mem_state;

    modport master (
        output complete_instr, complete_data, ir_dec, ir_exe, nzp,
        input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
               bypass_mem_1, mem_state
    );

    modport slave (
        input  complete_instr, complete_data, ir_dec, ir_exe, nzp,
        output enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
               bypass_mem_1, mem_state
    );
endinterface

// File: rtl/lc3_pipeline_controller_bypass_detect.sv
// Combinational operand-bypass decode between decode and execute stages.
//   ir_dec, ir_exe : instructions held in decode / execute
//   v_dec, v_exe   : stage valid bits; all bypasses are 0 unless both are set
//   bypass_alu_1   : SR1 of decode comes from the execute ALU result
//   bypass_alu_2   : SR2 (register-mode ADD/AND) or store source comes from ALU
//   bypass_mem_1   : SR1 of decode comes from memory read data (load in execute)
module lc3_bypass_detect
    import lc3_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic [INSTR_W-1:0] ir_dec,
    input  logic [INSTR_W-1:0] ir_exe,
    input  logic               v_dec,
    input  logic               v_exe,
    output logic               bypass_alu_1,
    output logic               bypass_alu_2,
    output logic               bypass_mem_1
);
    logic [3:0] op_dec;
    logic [3:0] op_exe;
    logic [2:0] dr_exe;
    logic       both_valid;
    logic       sr1_hit;
    logic       sr2_hit;
    logic       st_hit;
    logic       unused_bits;

    assign unused_bits = ^{ir_dec[4:3], ir_exe[8:0]};

    always_comb begin
        op_dec     = ir_dec[15:12];
        op_exe     = ir_exe[15:12];
        dr_exe     = ir_exe[11:9];
        both_valid = v_dec & v_exe;

        sr1_hit = reads_sr1(op_dec) && (ir_dec[8:6] == dr_exe);
        // bit 5 selects immediate mode, in which [2:0] is not a register.
        sr2_hit = ((op_dec == OP_ADD) || (op_dec == OP_AND)) && !ir_dec[5] &&
                  (ir_dec[2:0] == dr_exe);
        // Stores carry their source register in the DR field position.
        st_hit  = is_store(op_dec) && (ir_dec[11:9] == dr_exe);

        bypass_alu_1 = both_valid && is_alu(op_exe) && sr1_hit;
        bypass_alu_2 = both_valid && is_alu(op_exe) && (sr2_hit || st_hit);
        bypass_mem_1 = both_valid && is_load(op_exe) && sr1_hit;
    end
endmodule

// File: rtl/lc3_pipeline_controller.sv
// Central controller of the 5-stage LC-3 pipeline.
//   clock : system clock
//   reset : synchronous, active-high; all outputs forced inactive while high
//   bus   : lc3_pipeline_controller_if.slave (status/IR in, enables/selects out)
// Parameters: INSTR_W instruction width, BR_HOLD fetch-freeze cycles after a
// control op is decoded (2..7).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_RUN    | normal flow; stages advance on complete_instr
// S_MREAD  | data read in progress; full stall, writeback on complete_data
// S_MIND   | indirect pointer read for LDI/STI; full stall
// S_MWRITE | data write in progress; full stall
module lc3_pipeline_controller
    import lc3_ctrl_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int BR_HOLD = 3
) (
    input logic                      clock,
    input logic                      reset,
    lc3_pipeline_controller_if.slave bus
);
    ctrl_state_t state;
    ctrl_state_t state_nx;
    mem_state_t  mem_code;

    logic       v_dec;
    logic       v_exe;
    logic       v_wb;
    logic [2:0] br_cnt;
    logic       ind_load;

    logic [3:0] op_dec;
    logic [3:0] op_exe;
    logic       fetch_go;
    logic       dec_go;
    logic       exe_go;
    logic       mread_done;
    logic       ctrl_dec;

    logic       byp_alu_1;
    logic       byp_alu_2;
    logic       byp_mem_1;

    lc3_bypass_detect #(.INSTR_W(INSTR_W)) u_bypass (
        .ir_dec       (bus.ir_dec),
        .ir_exe       (bus.ir_exe),
        .v_dec        (v_dec),
        .v_exe        (v_exe),
        .bypass_alu_1 (byp_alu_1),
        .bypass_alu_2 (byp_alu_2),
        .bypass_mem_1 (byp_mem_1)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        op_dec     = bus.ir_dec[15:12];
        op_exe     = bus.ir_exe[15:12];
        state_nx   = state;
        mem_code   = MEM_IDLE;
        fetch_go   = 1'b0;
        dec_go     = 1'b0;
        exe_go     = 1'b0;
        mread_done = 1'b0;

        case (state)
            S_RUN: begin
                fetch_go = !reset && bus.complete_instr && (br_cnt == 3'd0);
                dec_go   = !reset && bus.complete_instr && v_dec;
                exe_go   = !reset && bus.complete_instr && v_exe;
                if (exe_go) begin
                    if ((op_exe == OP_LD) || (op_exe == OP_LDR)) begin
                        state_nx = S_MREAD;
                    end else if ((op_exe == OP_LDI) || (op_exe == OP_STI)) begin
                        state_nx = S_MIND;
                    end else if ((op_exe == OP_ST) || (op_exe == OP_STR)) begin
                        state_nx = S_MWRITE;
                    end
                end
            end
            S_MREAD: begin
                mem_code   = MEM_READ;
                mread_done = !reset && bus.complete_data;
                if (bus.complete_data) state_nx = S_RUN;
            end
            S_MIND: begin
                mem_code = MEM_IND;
                if (bus.complete_data) state_nx = ind_load ? S_MREAD : S_MWRITE;
            end
            S_MWRITE: begin
                mem_code = MEM_WRITE;
                if (bus.complete_data) state_nx = S_RUN;
            end
            default: state_nx = S_RUN;
        endcase

        ctrl_dec = dec_go && is_ctrl(op_dec);

        bus.enable_updatePC  = fetch_go;
        bus.enable_fetch     = fetch_go;
        bus.enable_decode    = dec_go;
        bus.enable_execute   = exe_go;
        bus.enable_writeback = !reset && (v_wb || mread_done);
        // JMP always redirects; BR only when its n/z/p mask meets the codes.
        bus.br_taken         = exe_go && is_ctrl(op_exe) &&
                               ((op_exe == OP_JMP) || ((bus.ir_exe[11:9] & bus.nzp) != 3'b000));
        bus.bypass_alu_1     = !reset && byp_alu_1;
        bus.bypass_alu_2     = !reset && byp_alu_2;
        bus.bypass_mem_1     = !reset && byp_mem_1;
        bus.mem_state        = reset ? MEM_IDLE : mem_code;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v_dec    <= 1'b0;
            v_exe    <= 1'b0;
            v_wb     <= 1'b0;
            br_cnt   <= 3'd0;
            ind_load <= 1'b0;
        end else begin
            // A control op in decode squashes whatever was fetched behind it.
            if (ctrl_dec) begin
                v_dec <= 1'b0;
            end else if (fetch_go) begin
                v_dec <= 1'b1;
            end else if (dec_go) begin
                v_dec <= 1'b0;
            end

            if (dec_go) begin
                v_exe <= v_dec;
            end else if (exe_go) begin
                v_exe <= 1'b0;
            end

            // ALU results write back the cycle after execute; loads write in MREAD.
            v_wb <= exe_go && is_alu(op_exe);

            if (ctrl_dec) begin
                br_cnt <= 3'(BR_HOLD);
            end else if (br_cnt != 3'd0) begin
                br_cnt <= br_cnt - 3'd1;
            end

            // Remember LDI vs STI so MIND does not depend on ir_exe staying put.
            if (exe_go) ind_load <= (op_exe == OP_LDI);
        end
    end
endmodule

// File: tb/tb_lc3_pipeline_controller.sv
// Scoreboard bench for lc3_pipeline_controller. The stimulus process drives
// one directed vector per cycle and queues the hand-computed output vector;
// a monitor pops and compares on each falling edge.
// Vector layout: {updatePC, fetch, decode, execute, writeback, br_taken,
//                 bypass_alu_1, bypass_alu_2, bypass_mem_1, mem_state[1:0]}
module tb_lc3_pipeline_controller;
    import lc3_ctrl_pkg::*;

    localparam logic [15:0] I_NOP   = 16'h1020; // ADD R0,R0,#0
    localparam logic [15:0] I_ADD1  = 16'h1283; // ADD R1,R2,R3
    localparam logic [15:0] I_ADD2  = 16'h1841; // ADD R4,R1,R1
    localparam logic [15:0] I_LDR   = 16'h6440; // LDR R2,R1,#0
    localparam logic [15:0] I_ADDI  = 16'h1AA1; // ADD R5,R2,#1
    localparam logic [15:0] I_STI   = 16'hB605; // STI R3,#5
    localparam logic [15:0] I_BRZ   = 16'h0405; // BRz #5
    localparam logic [15:0] I_BRN   = 16'h0803; // BRn #3
    localparam logic [15:0] I_LD    = 16'h2201; // LD R1,#1
    localparam logic [15:0] I_JMP   = 16'hC080; // JMP R2

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lc3_pipeline_controller_if #(.INSTR_W(16)) bus ();

    lc3_pipeline_controller #(.INSTR_W(16), .BR_HOLD(3)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [10:0] vec;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step(input logic r, input logic ci, input logic cd,
                        input logic [15:0] ird, input logic [15:0] ire,
                        input logic [2:0] nzp, input logic [10:0] exp_vec,
                        input string name);
        @(posedge clk);
        #1;
        rst                = r;
        bus.complete_instr = ci;
        bus.complete_data  = cd;
        bus.ir_dec         = ird;
        bus.ir_exe         = ire;
        bus.nzp            = nzp;
        sb_q.push_back('{vec: exp_vec, name: name});
    endtask

    initial begin : monitor
        exp_t        e;
        logic [10:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {bus.enable_updatePC, bus.enable_fetch, bus.enable_decode,
                       bus.enable_execute, bus.enable_writeback, bus.br_taken,
                       bus.bypass_alu_1, bus.bypass_alu_2, bus.bypass_mem_1,
                       2'(bus.mem_state)};
                checks++;
                if (act !== e.vec) begin
                    errors++;
                    $display("FAIL %s: actual %b required %b", e.name, act, e.vec);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst                = 1'b1;
        bus.complete_instr = 1'b1;
        bus.complete_data  = 1'b0;
        bus.ir_dec         = I_NOP;
        bus.ir_exe         = I_NOP;
        bus.nzp            = 3'b000;

        //   rst   ci    cd    ir_dec  ir_exe  nzp     expected              name
        step(1'b1, 1'b1, 1'b0, I_NOP,  I_NOP,  3'b000, 11'b00000_0_000_11, "reset_1");
        step(1'b1, 1'b1, 1'b0, I_NOP,  I_NOP,  3'b000, 11'b00000_0_000_11, "reset_2");
        step(1'b1, 1'b1, 1'b0, I_NOP,  I_NOP,  3'b000, 11'b00000_0_000_11, "reset_3");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_NOP,  3'b000, 11'b11000_0_000_11, "first_fetch");
        step(1'b0, 1'b1, 1'b0, I_ADD1, I_NOP,  3'b000, 11'b11100_0_000_11, "first_decode");
        step(1'b0, 1'b1, 1'b0, I_ADD2, I_ADD1, 3'b000, 11'b11110_0_110_11, "add_bypass");
        step(1'b0, 1'b1, 1'b0, I_LDR,  I_ADD2, 3'b000, 11'b11111_0_000_11, "alu_writeback");
        step(1'b0, 1'b1, 1'b0, I_ADDI, I_LDR,  3'b000, 11'b11111_0_001_11, "load_bypass");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_LDR,  3'b000, 11'b00000_0_000_00, "mread_wait_1");
        step(1'b0, 1'b0, 1'b0, I_NOP,  I_LDR,  3'b000, 11'b00000_0_000_00, "mread_wait_2");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_LDR,  3'b000, 11'b00000_0_000_00, "mread_wait_3");
        step(1'b0, 1'b1, 1'b1, I_NOP,  I_LDR,  3'b000, 11'b00001_0_000_00, "mread_done");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_ADDI, 3'b000, 11'b11110_0_000_11, "after_load");
        step(1'b0, 1'b0, 1'b0, I_NOP,  I_NOP,  3'b000, 11'b00001_0_100_11, "instr_stall");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_STI,  3'b000, 11'b11110_0_000_11, "sti_issue");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_STI,  3'b000, 11'b00000_0_000_01, "mind_wait");
        step(1'b0, 1'b1, 1'b1, I_NOP,  I_STI,  3'b000, 11'b00000_0_000_01, "mind_done");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_STI,  3'b000, 11'b00000_0_000_10, "mwrite_wait_1");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_STI,  3'b000, 11'b00000_0_000_10, "mwrite_wait_2");
        step(1'b0, 1'b1, 1'b1, I_NOP,  I_STI,  3'b000, 11'b00000_0_000_10, "mwrite_done");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_NOP,  3'b000, 11'b11110_0_100_11, "after_store");
        step(1'b0, 1'b1, 1'b0, I_BRZ,  I_NOP,  3'b010, 11'b11111_0_000_11, "brz_decode");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_BRZ,  3'b010, 11'b00011_1_000_11, "brz_taken");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_BRZ,  3'b010, 11'b00000_0_000_11, "brz_hold_2");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_BRZ,  3'b010, 11'b00000_0_000_11, "brz_hold_1");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_NOP,  3'b010, 11'b11000_0_000_11, "brz_release");
        step(1'b0, 1'b1, 1'b0, I_BRN,  I_NOP,  3'b010, 11'b11100_0_000_11, "brn_decode");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_BRN,  3'b010, 11'b00010_0_000_11, "brn_not_taken");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_BRN,  3'b010, 11'b00000_0_000_11, "brn_hold_2");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_BRN,  3'b010, 11'b00000_0_000_11, "brn_hold_1");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_NOP,  3'b010, 11'b11000_0_000_11, "brn_release");
        step(1'b0, 1'b1, 1'b0, I_LD,   I_NOP,  3'b000, 11'b11100_0_000_11, "ld_decode");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_LD,   3'b000, 11'b11110_0_000_11, "ld_issue");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_LD,   3'b000, 11'b00000_0_000_00, "mread_pre_reset");
        step(1'b1, 1'b1, 1'b1, I_NOP,  I_LD,   3'b000, 11'b00000_0_000_11, "reset_in_mread");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_LD,   3'b000, 11'b11000_0_000_11, "after_mread_reset");
        step(1'b0, 1'b1, 1'b0, I_JMP,  I_NOP,  3'b000, 11'b11100_0_000_11, "jmp_decode");
        step(1'b0, 1'b1, 1'b0, I_NOP,  I_JMP,  3'b000, 11'b00010_1_000_11, "jmp_taken");

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual %0d entries left required 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
